// File: rtl/uat_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/stop serialiser.
// Defining UAT_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uat_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 gl_reset_n,
  input  logic [DATA_BITS-1:0] dIn,
  input  logic                 dValid,
  output logic                 dReady,
  output logic                 dOut,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shifter, shifter_n;
  logic [DATA_BITS-1:0] hold, hold_n;
  logic                 hold_full, hold_full_n;
  logic                 dout_r, dout_n;
  logic                 last;
`ifdef UAT_PARITY_EN
  logic                 par, par_n;
`endif

  assign last   = (cnt == CNT_LAST);
  assign dOut   = dout_r;
  assign dReady = ~hold_full;
  assign busy   = (state != IDLE) || hold_full;

  always_ff @(posedge clk or negedge gl_reset_n) begin
    if (!gl_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      dout_r    <= 1'b1;
`ifdef UAT_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shifter   <= shifter_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      dout_r    <= dout_n;
`ifdef UAT_PARITY_EN
      par       <= par_n;
`endif
    end
  end

  // dOut is computed for the state being entered, so the line is a clean flop output.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shifter_n   = shifter;
    hold_n      = hold;
    hold_full_n = hold_full;
    dout_n      = dout_r;
`ifdef UAT_PARITY_EN
    par_n       = par;
`endif

    // Acceptance and hold-to-shifter transfer are mutually exclusive on hold_full.
    if (dValid && !hold_full) begin
      hold_n      = dIn;
      hold_full_n = 1'b1;
    end

    case (state)
      IDLE: begin
        cnt_n  = '0;
        dout_n = 1'b1;
        if (hold_full) begin
          shifter_n   = hold;
          hold_full_n = 1'b0;
          state_n     = START;
          dout_n      = 1'b0;
`ifdef UAT_PARITY_EN
          par_n       = ^hold;
`endif
        end
      end
      START: begin
        cnt_n = cnt + CW'(1);
        if (last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          dout_n  = shifter[0];
        end
      end
      DATA: begin
        cnt_n = cnt + CW'(1);
        if (last) begin
          cnt_n     = '0;
          shifter_n = shifter >> 1;
          if (idx == IDX_LAST) begin
`ifdef UAT_PARITY_EN
            state_n = PARITY;
            dout_n  = par;
`else
            state_n = STOP;
            dout_n  = 1'b1;
`endif
          end else begin
            idx_n  = idx + 3'd1;
            dout_n = shifter[1];
          end
        end
      end
`ifdef UAT_PARITY_EN
      PARITY: begin
        cnt_n = cnt + CW'(1);
        if (last) begin
          cnt_n   = '0;
          state_n = STOP;
          dout_n  = 1'b1;
        end
      end
`endif
      STOP: begin
        cnt_n = cnt + CW'(1);
        if (last) begin
          cnt_n = '0;
          if (hold_full) begin
            shifter_n   = hold;
            hold_full_n = 1'b0;
            state_n     = START;
            dout_n      = 1'b0;
`ifdef UAT_PARITY_EN
            par_n       = ^hold;
`endif
          end else begin
            state_n = IDLE;
            dout_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        dout_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uat_tx.sv
// Directed bench for uat_tx: table of single-byte frames plus back-to-back,
// backpressure and mid-frame reset sequences.
module tb_uat_tx;

  localparam int C = 8;
`ifdef UAT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       gl_reset_n;
  logic [7:0] dIn;
  logic       dValid;
  logic       dReady;
  logic       dOut;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uat_tx #(.CLKS_PER_BIT(8), .DATA_BITS(8)) dut (
    .clk        (clk),
    .gl_reset_n (gl_reset_n),
    .dIn        (dIn),
    .dValid     (dValid),
    .dReady     (dReady),
    .dOut       (dOut),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // pat is the 10-bit line sequence, pat[9] transmitted first (start ... stop).
  typedef struct {
    logic [7:0] d;
    logic [9:0] pat;
    logic       par;
  } vec_t;

  vec_t tbl [7];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [9:0] pat, input logic par, input int b);
    if (b <= 8) return pat[9-b];
    if (b == NB - 1) return pat[0];
    return par;
  endfunction

  task automatic send(input logic [7:0] d);
    dIn    = d;
    dValid = 1'b1;
    @(negedge clk);
    dValid = 1'b0;
  endtask

  // Entered at the negedge showing the first start-bit clock, or one earlier when adv=1.
  task automatic check_frame(input string nm, input logic [9:0] pat, input logic par, input bit adv);
    for (int k = 0; k < NB * C; k++) begin
      if (k > 0 || adv) @(negedge clk);
      cmp($sformatf("%s_bit%0d_clk%0d", nm, k / C, k % C), {31'd0, dOut}, {31'd0, exp_bit(pat, par, k / C)});
      if (k == 0) cmp({nm, "_busy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    cmp({nm, "_idle_busy"},  {31'd0, busy},   32'd0);
    cmp({nm, "_idle_ready"}, {31'd0, dReady}, 32'd1);
    cmp({nm, "_idle_dout"},  {31'd0, dOut},   32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
    tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
    tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
    tbl[3] = '{8'h55, 10'b0101010101, 1'b0};
    tbl[4] = '{8'h01, 10'b0100000001, 1'b1};
    tbl[5] = '{8'h07, 10'b0111000001, 1'b1};
    tbl[6] = '{8'h03, 10'b0110000001, 1'b0};

    gl_reset_n = 1'b0;
    dValid     = 1'b0;
    dIn        = 8'h00;

    // reset and idle
    repeat (2) @(negedge clk);
    cmp("rst_dout",  {31'd0, dOut},   32'd1);
    cmp("rst_ready", {31'd0, dReady}, 32'd1);
    cmp("rst_busy",  {31'd0, busy},   32'd0);
    gl_reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cmp("idle_dout",  {31'd0, dOut},   32'd1);
      cmp("idle_ready", {31'd0, dReady}, 32'd1);
      cmp("idle_busy",  {31'd0, busy},   32'd0);
    end

    // single frames from the table
    for (int v = 0; v < 7; v++) begin
      send(tbl[v].d);
      cmp($sformatf("v%0d_ready_drop", v), {31'd0, dReady}, 32'd0);
      cmp($sformatf("v%0d_busy_rise", v),  {31'd0, busy},   32'd1);
      cmp($sformatf("v%0d_lat1_dout", v),  {31'd0, dOut},   32'd1);
      @(negedge clk);
      cmp($sformatf("v%0d_lat2_ready", v), {31'd0, dReady}, 32'd1);
      check_frame($sformatf("v%0d", v), tbl[v].pat, tbl[v].par, 1'b0);
      check_idle($sformatf("v%0d", v));
      repeat (3) @(negedge clk);
    end

    // back-to-back 3C then C3
    send(8'h3C);
    @(negedge clk);
    fork
      begin
        check_frame("b2b_3c", 10'b0001111001, 1'b0, 1'b0);
        check_frame("b2b_c3", 10'b0110000111, 1'b0, 1'b1);
      end
      begin
        repeat (10) @(negedge clk);
        dIn    = 8'hC3;
        dValid = 1'b1;
        @(negedge clk);
        dValid = 1'b0;
        cmp("b2b_ready_drop", {31'd0, dReady}, 32'd0);
        cmp("b2b_busy",       {31'd0, busy},   32'd1);
      end
    join
    check_idle("b2b");

    // backpressure: FF held while hold register is full
    send(8'h55);
    @(negedge clk);
    fork
      begin
        check_frame("bp_55", 10'b0101010101, 1'b0, 1'b0);
        check_frame("bp_a5", 10'b0101001011, 1'b0, 1'b1);
        check_frame("bp_ff", 10'b0111111111, 1'b0, 1'b1);
      end
      begin
        bit seen;
        repeat (3) @(negedge clk);
        dIn    = 8'hA5;
        dValid = 1'b1;
        @(negedge clk);
        dIn = 8'hFF;
        cmp("bp_ready_full", {31'd0, dReady}, 32'd0);
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          cmp("bp_ready_held", {31'd0, dReady}, 32'd0);
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          if (dReady) seen = 1'b1;
        end
        cmp("bp_ready_return", {31'd0, seen}, 32'd1);
        @(negedge clk);
        dValid = 1'b0;
      end
    join
    check_idle("bp");

    // reset during data bit 3 of 00
    send(8'h00);
    @(negedge clk);
    repeat (35) @(negedge clk);
    cmp("mid_pre_dout", {31'd0, dOut}, 32'd0);
    #1 gl_reset_n = 1'b0;
    #1;
    cmp("mid_async_dout",  {31'd0, dOut},   32'd1);
    cmp("mid_async_ready", {31'd0, dReady}, 32'd1);
    cmp("mid_async_busy",  {31'd0, busy},   32'd0);
    repeat (2) @(negedge clk);
    gl_reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cmp("mid_post_dout",  {31'd0, dOut},   32'd1);
      cmp("mid_post_ready", {31'd0, dReady}, 32'd1);
      cmp("mid_post_busy",  {31'd0, busy},   32'd0);
    end
    send(8'h55);
    @(negedge clk);
    check_frame("mid_55", 10'b0101010101, 1'b0, 1'b0);
    check_idle("mid_55");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
